// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Optional build macro used by the arbiter: SRAM_ARB_RR_EN (round-robin grant).
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_STROBE,
        R_DONE
    } state_t;

    typedef enum logic {
        REQ_WR = 1'b0,
        REQ_RD = 1'b1
    } req_id_t;

    typedef struct packed {
        logic we_n;
        logic oe_n;
        logic ce_n;
        logic lb_n;
        logic ub_n;
        logic dq_oe;
    } ctrl_t;

    localparam ctrl_t IDLE_CTRL = '{we_n: 1'b1, oe_n: 1'b1, ce_n: 1'b1,
                                    lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};

    // Pin levels the SRAM should see while the FSM sits in state s.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = IDLE_CTRL;
        case (s)
            W_SETUP, W_HOLD: begin
                c.ce_n  = 1'b0;
                c.lb_n  = 1'b0;
                c.ub_n  = 1'b0;
                c.dq_oe = 1'b1;
            end
            W_STROBE: begin
                c.ce_n  = 1'b0;
                c.lb_n  = 1'b0;
                c.ub_n  = 1'b0;
                c.dq_oe = 1'b1;
                c.we_n  = 1'b0;
            end
            R_STROBE: begin
                c.ce_n = 1'b0;
                c.lb_n = 1'b0;
                c.ub_n = 1'b0;
                c.oe_n = 1'b0;
            end
            R_DONE: begin
                c.ce_n = 1'b0;
                c.lb_n = 1'b0;
                c.ub_n = 1'b0;
            end
            default: c = IDLE_CTRL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes and SRAM pad signals of the arbiter.
// slave: the arbiter; master: requesters plus pad side.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_ack;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_busy;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_dq_out;
    logic              o_sram_dq_oe;
    logic [DATA_W-1:0] i_sram_dq_in;
    logic              o_sram_we_n;
    logic              o_sram_oe_n;
    logic              o_sram_ce_n;
    logic              o_sram_lb_n;
    logic              o_sram_ub_n;

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_sram_dq_in,
        output o_wr_ack, o_rd_ack, o_rd_data, o_busy, o_sram_addr, o_sram_dq_out,
               o_sram_dq_oe, o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n,
               o_sram_ub_n
    );

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_sram_dq_in,
        input  o_wr_ack, o_rd_ack, o_rd_data, o_busy, o_sram_addr, o_sram_dq_out,
               o_sram_dq_oe, o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n,
               o_sram_ub_n
    );
endinterface

// File: rtl/sram_arbiter_timer.sv
// Strobe-width down-counter: load arms it with WAIT_CYC-1, done flags terminal count.
module sram_arb_timer #(
    parameter int WAIT_CYC = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic load,
    output logic done
);
    localparam int CNT_W = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Count down to zero and park there until the next load.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/sram_arbiter.sv
// Arbiter owning the async SRAM pins for the recorder (write) and DSP (read) paths.
// Build macro SRAM_ARB_RR_EN: round-robin on ties; otherwise reads always win.
//
// state    | meaning
// IDLE     | pins inactive, bus turnaround, arbitration happens here only
// W_SETUP  | chip selected, data driven, address settling before WE_N
// W_STROBE | WE_N low for WAIT_CYC cycles
// W_HOLD   | WE_N released, data still driven, write ack
// R_STROBE | OE_N low for WAIT_CYC cycles, data captured on the last edge
// R_DONE   | OE_N released, read ack with registered data
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input logic          i_clk,
    input logic          i_rst_n,
    sram_arbiter_if.slave bus
);
    state_t            state, state_nxt;
    req_id_t           gnt;
    logic              any_req;
    logic              tmr_load, tmr_done;
    ctrl_t             ctrl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dq_out_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_ack_q, rd_ack_q;

    assign any_req = bus.i_rd_req | bus.i_wr_req;

`ifdef SRAM_ARB_RR_EN
    req_id_t last_gnt;

    // On a tie, grant whoever did not win last time.
    always_comb begin
        gnt = REQ_RD;
        if (bus.i_rd_req && bus.i_wr_req)
            gnt = (last_gnt == REQ_RD) ? REQ_WR : REQ_RD;
        else if (bus.i_wr_req)
            gnt = REQ_WR;
    end

    // Remember the last winner; starts at "write" so the first tie goes to reads.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            last_gnt <= REQ_WR;
        else if (state == IDLE && any_req)
            last_gnt <= gnt;
    end
`else
    // Playback is real-time, so reads always win.
    assign gnt = bus.i_rd_req ? REQ_RD : REQ_WR;
`endif

    sram_arb_timer #(.WAIT_CYC(WAIT_CYC)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (tmr_load),
        .done    (tmr_done)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; the timer is loaded on every entry into a strobe state.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (gnt == REQ_RD) begin
                        state_nxt = R_STROBE;
                        tmr_load  = 1'b1;
                    end else begin
                        state_nxt = W_SETUP;
                    end
                end
            end
            W_SETUP: begin
                state_nxt = W_STROBE;
                tmr_load  = 1'b1;
            end
            W_STROBE: if (tmr_done) state_nxt = W_HOLD;
            W_HOLD:   state_nxt = IDLE;
            R_STROBE: if (tmr_done) state_nxt = R_DONE;
            R_DONE:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Pin and handshake registers follow the state being entered, so every pad output is a flop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ctrl_q    <= IDLE_CTRL;
            addr_q    <= '0;
            dq_out_q  <= '0;
            rd_data_q <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
        end else begin
            ctrl_q   <= state_ctrl(state_nxt);
            wr_ack_q <= (state_nxt == W_HOLD);
            rd_ack_q <= (state_nxt == R_DONE);
            if (state == IDLE && state_nxt == R_STROBE)
                addr_q <= bus.i_rd_addr;
            if (state == IDLE && state_nxt == W_SETUP) begin
                addr_q   <= bus.i_wr_addr;
                dq_out_q <= bus.i_wr_data;
            end
            if (state == R_STROBE && tmr_done)
                rd_data_q <= bus.i_sram_dq_in;
        end
    end

    assign bus.o_busy        = (state != IDLE);
    assign bus.o_wr_ack      = wr_ack_q;
    assign bus.o_rd_ack      = rd_ack_q;
    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_sram_addr   = addr_q;
    assign bus.o_sram_dq_out = dq_out_q;
    assign bus.o_sram_dq_oe  = ctrl_q.dq_oe;
    assign bus.o_sram_we_n   = ctrl_q.we_n;
    assign bus.o_sram_oe_n   = ctrl_q.oe_n;
    assign bus.o_sram_ce_n   = ctrl_q.ce_n;
    assign bus.o_sram_lb_n   = ctrl_q.lb_n;
    assign bus.o_sram_ub_n   = ctrl_q.ub_n;
endmodule
